// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares a single-port synchronous instruction RAM between the
//            pipeline IF stage (read only) and the loader/debug port
//            (read/write). The loader has priority. A burst counter bounds
//            how long the IF stage can be starved.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                 c_CNT_W     = $clog2(MAX_LD_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(MAX_LD_BURST);

  // Owner encoding of the response tag.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LD = 1'b1
  } owner_t;

  logic [c_CNT_W-1:0] r_burst_cnt;
  logic               r_tag_valid;
  owner_t             r_tag_owner;
  logic               r_tag_oor;

  logic               w_force_if;
  logic               w_if_gnt;
  logic               w_ld_gnt;
  logic               w_any_gnt;
  logic [31:0]        w_sel_addr;
  logic               w_sel_oor;
  logic               w_sel_read;

  // A byte address is out of range when it is misaligned or lies beyond
  // the RAM depth. Such accesses are granted but never reach the RAM.
  function automatic logic f_oor(input logic [31:0] a);
    return ((a >> (ADDR_W + 2)) != 32'd0) || (a[1:0] != 2'b00);
  endfunction

  // Grant selection: the loader wins unless IF has waited out a full burst.
  // Reset masks both requesters.
  always_comb begin
    w_force_if = if_req && (r_burst_cnt == c_BURST_MAX);
    w_ld_gnt   = reset && ld_req && !w_force_if;
    w_if_gnt   = reset && if_req && !w_ld_gnt;
    w_any_gnt  = w_if_gnt || w_ld_gnt;
    w_sel_addr = w_ld_gnt ? ld_addr : if_addr;
    w_sel_oor  = f_oor(w_sel_addr);
    w_sel_read = w_if_gnt || (w_ld_gnt && !ld_we);
  end

  // Count loader grants that kept a waiting IF request out; saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_burst_cnt <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_burst_cnt <= '0;
    end else if (w_ld_gnt && (r_burst_cnt != c_BURST_MAX)) begin
      r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
    end
  end

  // Response tag: remembers who issued the read of the previous cycle and
  // whether its data must be replaced by a NOP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_valid <= 1'b0;
      r_tag_owner <= OWNER_IF;
      r_tag_oor   <= 1'b0;
    end else begin
      r_tag_valid <= w_any_gnt && w_sel_read;
      r_tag_owner <= w_ld_gnt ? OWNER_LD : OWNER_IF;
      r_tag_oor   <= w_sel_oor;
    end
  end

  // Grants, stall and the RAM drive. All RAM signals idle at zero.
  always_comb begin
    if_gnt    = w_if_gnt;
    ld_gnt    = w_ld_gnt;
    cpu_hold  = reset && if_req && !w_if_gnt;
    mem_en    = w_any_gnt && !w_sel_oor;
    mem_we    = w_any_gnt && !w_sel_oor && w_ld_gnt && ld_we;
    mem_addr  = w_any_gnt ? w_sel_addr[ADDR_W+1:2] : '0;
    mem_wdata = w_any_gnt ? ld_wdata : '0;
  end

  // Route the RAM data to the owner of last cycle's read; others read 0.
  always_comb begin
    if_rvalid = r_tag_valid && (r_tag_owner == OWNER_IF);
    ld_rvalid = r_tag_valid && (r_tag_owner == OWNER_LD);
    if_rdata  = (if_rvalid && !r_tag_oor) ? mem_rdata : '0;
    ld_rdata  = (ld_rvalid && !r_tag_oor) ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port synchronous instruction RAM between two requesters.
- Requester one is the pipeline IF stage, which only reads.
- Requester two is the program loader/debug port, which reads and writes.
- The loader has priority, bounded by a starvation counter so the IF stage keeps progressing.
- Sits between the IF stage, the loader, and the instruction RAM macro. The RAM has 1-cycle registered read latency.

Parameters:
- ADDR_W, 8, RAM word-index width; RAM depth is 2^ADDR_W words, byte address bits [ADDR_W+1:2].
- DATA_W, 32, instruction/data word width.
- MAX_LD_BURST, 4, maximum consecutive loader grants while IF is requesting, before IF is forced a grant.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- if_req  input  1  IF stage read request
- if_addr  input  32  IF byte address
- if_gnt  output  1  IF request accepted this cycle
- if_rvalid  output  1  IF read data valid
- if_rdata  output  DATA_W  IF read data
- ld_req  input  1  loader request
- ld_we  input  1  loader write (1) / read (0)
- ld_addr  input  32  loader byte address
- ld_wdata  input  DATA_W  loader write data
- ld_gnt  output  1  loader request accepted this cycle
- ld_rvalid  output  1  loader read data valid
- ld_rdata  output  DATA_W  loader read data
- cpu_hold  output  1  high in any cycle where if_req=1 and if_gnt=0; IF stage must stall PC
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM word address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en=1, mem_we=0

Behaviour:

Grant
- Grant is combinational in the request cycle; at most one of if_gnt and ld_gnt is high.
- Default: ld_req wins over if_req.
- burst_cnt counts consecutive ld_gnt cycles during which if_req was also high.
- When burst_cnt == MAX_LD_BURST and if_req=1, IF wins that cycle regardless of ld_req.
- burst_cnt clears on any if_gnt, or on any cycle with if_req=0. It saturates at MAX_LD_BURST.

Address decode
- Word index = addr[ADDR_W+1:2].
- A request is "out-of-range" if addr[31:ADDR_W+2] != 0 or addr[1:0] != 0.
- Out-of-range requests are still granted, but mem_en stays 0.
- An out-of-range read returns 32'h00000000 (NOP) with normal 1-cycle latency.
- An out-of-range write is dropped silently.

Memory drive
- On a granted in-range request: mem_en=1, mem_we=ld_we for the loader, mem_we=0 for IF.
- mem_addr = word index; mem_wdata = ld_wdata.
- When nothing is granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Response
- A registered tag (owner, is_read, is_oor) records each granted read.
- Next cycle, exactly one of if_rvalid or ld_rvalid is high for that read.
- rdata = mem_rdata, or 0 if is_oor.
- Non-valid rdata outputs are driven 0.
- Loader writes produce no rvalid.
- Latency is 1 cycle for every read, and back-to-back reads are fully pipelined (one per cycle).

Hazards
- A loader write to word N at cycle t, followed by any read of N at t+1 or later, returns the new data.
- A grant in the same cycle as a response is legal.

Reset (reset=0 at a rising edge)
- burst_cnt=0 and the response tag is cleared.
- All outputs read 0 in the following cycle: no rvalid, gnt low, mem_en low.
- A read granted in the cycle where reset is sampled never produces rvalid.
- While reset is low, requests are ignored and both grants are 0.

Test Plan:
1. Reset then IF-only stream: if_req=1, if_addr=0,4,8 on consecutive cycles.
   -> if_gnt=1 each cycle; mem_addr=0,1,2; if_rvalid 1 cycle later each; if_rdata equals RAM words 0,1,2; cpu_hold=0.
2. Loader writes 32'h2018000d to byte addr 0x08, then IF reads 0x08 on the next cycle.
   -> mem_we=1, mem_addr=2 in the write cycle; IF read returns 32'h2018000d one cycle after its grant.
3. Contention with MAX_LD_BURST=4: if_req and ld_req (reads) both held high for 10 cycles.
   -> grant pattern L,L,L,L,I,L,L,L,L,I; cpu_hold high on the 8 L cycles; each rvalid goes to the correct owner one cycle later.
4. Out-of-range: IF reads 0x400, then 0x06; loader writes to 0x404.
   -> both reads granted with mem_en=0; if_rdata=0 with if_rvalid=1; RAM contents unchanged; no ld_rvalid for the write.
5. Reset mid-operation: loader read granted at cycle t with reset=0 sampled at t.
   -> ld_rvalid=0 at t+1; burst_cnt=0; first post-reset IF request granted immediately even with ld_req idle.
6. Idle/edge: both requests low.
   -> mem_en=0, all rvalid=0, all rdata=0; a single-cycle if_req pulse gets if_rvalid exactly one cycle later.
